// File: rtl/astro_pkg.sv
// Shared constants and state encoding for the window statistics engine.
// Accumulator widths are sized exactly for a 16x16 window of 8-bit pixels.
package astro_pkg;

  localparam int WIN_DIM   = 16;
  localparam int PIX_W     = 8;
  localparam int ROW_SUM_W = 12;
  localparam int ROW_SOS_W = 20;
  localparam int SUM_W     = 16;
  localparam int SOS_W     = 24;
  localparam int IDX_W     = 12;
  localparam int CNT_W     = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    VALID = 2'd2
  } state_t;

endpackage

// File: rtl/row_stats.sv
// Combinational sum and sum of squares of one window row.
// A 16-pixel row of 0xFF peaks at 4080 and 1040400, so 12/20 bits are enough.
module row_stats #(
  parameter int WIN_DIM = astro_pkg::WIN_DIM,
  parameter int PIX_W   = astro_pkg::PIX_W
) (
  input  logic [WIN_DIM-1:0][PIX_W-1:0] row,
  output logic [11:0]                   row_sum,
  output logic [19:0]                   row_sos
);

  import astro_pkg::*;

  logic [ROW_SUM_W-1:0] sum_s;
  logic [ROW_SOS_W-1:0] sos_s;
  logic [ROW_SOS_W-1:0] pix_s;

  // adder tree over the row, squares formed at full row-sos width
  always_comb begin
    sum_s = {ROW_SUM_W{1'b0}};
    sos_s = {ROW_SOS_W{1'b0}};
    pix_s = {ROW_SOS_W{1'b0}};
    for (int i = 0; i < WIN_DIM; i++) begin
      pix_s = {{(ROW_SOS_W-PIX_W){1'b0}}, row[i]};
      sum_s = sum_s + pix_s[ROW_SUM_W-1:0];
      sos_s = sos_s + pix_s * pix_s;
    end
  end

  // outputs driven straight from the combinational result
  always_comb begin
    row_sum = sum_s;
    row_sos = sos_s;
  end

endmodule

// File: rtl/window_stats.sv
// Captures a 16x16 window, accumulates one row per cycle into sum and
// sum-of-squares, then holds the result until downstream accepts it.
module window_stats #(
  parameter int WIN_DIM = astro_pkg::WIN_DIM,
  parameter int PIX_W   = astro_pkg::PIX_W
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic [WIN_DIM-1:0][WIN_DIM-1:0][PIX_W-1:0] window_data,
  input  logic                                      window_ready,
  output logic                                      ack,
  output logic [15:0]                               win_sum,
  output logic [23:0]                               win_sos,
  output logic [11:0]                               window_index,
  output logic                                      result_valid,
  input  logic                                      result_ready
);

  import astro_pkg::*;

  state_t state_r;
  state_t state_s;

  logic [WIN_DIM-1:0][WIN_DIM-1:0][PIX_W-1:0] window_r;
  logic [CNT_W-1:0]     row_cnt_r;
  logic [SUM_W-1:0]     sum_r;
  logic [SOS_W-1:0]     sos_r;
  logic [IDX_W-1:0]     idx_r;
  logic                 ack_r;
  logic                 valid_r;

  logic                 capture_s;
  logic                 done_s;
  logic                 last_row_s;
  logic [ROW_SUM_W-1:0] row_sum_s;
  logic [ROW_SOS_W-1:0] row_sos_s;

  row_stats #(
    .WIN_DIM (WIN_DIM),
    .PIX_W   (PIX_W)
  ) u_row_stats (
    .row     (window_r[row_cnt_r]),
    .row_sum (row_sum_s),
    .row_sos (row_sos_s)
  );

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // next-state logic and transfer strobes
  always_comb begin
    state_s    = state_r;
    capture_s  = 1'b0;
    done_s     = 1'b0;
    last_row_s = (row_cnt_r == CNT_W'(WIN_DIM - 1));
    case (state_r)
      IDLE: begin
        if (window_ready) begin
          capture_s = 1'b1;
          state_s   = ACCUM;
        end else begin
          state_s   = IDLE;
        end
      end
      ACCUM: begin
        if (last_row_s) begin
          state_s = VALID;
        end else begin
          state_s = ACCUM;
        end
      end
      VALID: begin
        // a simultaneous window_ready is deliberately left for the next edge
        if (result_ready) begin
          done_s  = 1'b1;
          state_s = IDLE;
        end else begin
          state_s = VALID;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // captured window; contents are don't-care until the first capture
  always_ff @(posedge clk) begin
    if (capture_s) begin
      window_r <= window_data;
    end
  end

  // accumulators, row counter, handshake flags and window index
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_r     <= 1'b0;
      valid_r   <= 1'b0;
      sum_r     <= {SUM_W{1'b0}};
      sos_r     <= {SOS_W{1'b0}};
      idx_r     <= {IDX_W{1'b0}};
      row_cnt_r <= {CNT_W{1'b0}};
    end else begin
      ack_r <= capture_s;
      if (capture_s) begin
        sum_r     <= {SUM_W{1'b0}};
        sos_r     <= {SOS_W{1'b0}};
        row_cnt_r <= {CNT_W{1'b0}};
      end else if (state_r == ACCUM) begin
        sum_r     <= sum_r + SUM_W'(row_sum_s);
        sos_r     <= sos_r + SOS_W'(row_sos_s);
        row_cnt_r <= row_cnt_r + 4'd1;
        if (last_row_s) begin
          valid_r <= 1'b1;
        end
      end else if (done_s) begin
        valid_r <= 1'b0;
        idx_r   <= idx_r + 12'd1;
      end
    end
  end

  assign ack          = ack_r;
  assign result_valid = valid_r;
  assign win_sum      = sum_r;
  assign win_sos      = sos_r;
  assign window_index = idx_r;

endmodule

// File: tb/tb_window_stats.sv
// Directed self-checking bench for window_stats: fixed pixel patterns with
// hand-computed sums, stall/handshake corner cases, reset and index wrap.
module tb_window_stats;

  logic                          clk;
  logic                          rst_n;
  logic [15:0][15:0][7:0]        window_data;
  logic                          window_ready;
  logic                          ack;
  logic [15:0]                   win_sum;
  logic [23:0]                   win_sos;
  logic [11:0]                   window_index;
  logic                          result_valid;
  logic                          result_ready;

  int total;
  int passes;

  window_stats dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .window_data  (window_data),
    .window_ready (window_ready),
    .ack          (ack),
    .win_sum      (win_sum),
    .win_sos      (win_sos),
    .window_index (window_index),
    .result_valid (result_valid),
    .result_ready (result_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic fill_const(input logic [7:0] v);
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++)
        window_data[r][c] = v;
  endtask

  task automatic fill_ramp();
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++)
        window_data[r][c] = 8'(r * 16 + c);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // raise window_ready until ack appears; returns with time just after the capture edge + 1
  task automatic wait_ack(input string tag);
    bit got;
    got = 1'b0;
    window_ready = 1'b1;
    for (int n = 0; n < 4 && !got; n++) begin
      tick();
      got = ack;
    end
    chk({tag, "_ack"}, 32'(got), 32'd1);
    window_ready = 1'b0;
  endtask

  task automatic do_window(input string tag, input logic [15:0] es, input logic [23:0] eo,
                           input logic [11:0] ei, input bit release_it);
    wait_ack(tag);
    tick();
    chk({tag, "_ack_once"}, 32'(ack), 32'd0);
    repeat (14) tick();
    chk({tag, "_not_yet_valid"}, 32'(result_valid), 32'd0);
    tick();
    chk({tag, "_valid"}, 32'(result_valid), 32'd1);
    chk({tag, "_sum"}, 32'(win_sum), 32'(es));
    chk({tag, "_sos"}, 32'(win_sos), 32'(eo));
    chk({tag, "_idx"}, 32'(window_index), 32'(ei));
    if (release_it) begin
      result_ready = 1'b1;
      tick();
      chk({tag, "_released"}, 32'(result_valid), 32'd0);
      result_ready = 1'b0;
    end
  endtask

  initial begin
    int stable_bad;
    int bulk_bad;
    int bulk_seen;
    logic [11:0] idx_4095;
    logic [11:0] idx_4096;
    bit got;

    total = 0;
    passes = 0;
    rst_n = 1'b0;
    window_ready = 1'b0;
    result_ready = 1'b0;
    fill_const(8'h00);
    #12;
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_valid", 32'(result_valid), 32'd0);
    chk("rst_sum", 32'(win_sum), 32'd0);
    chk("rst_sos", 32'(win_sos), 32'd0);
    chk("rst_idx", 32'(window_index), 32'd0);
    rst_n = 1'b1;
    tick();

    // basic patterns
    fill_const(8'h43);
    do_window("w43", 16'd17152, 24'd1149184, 12'd0, 1'b1);
    fill_const(8'hFF);
    do_window("wff", 16'd65280, 24'd16646400, 12'd1, 1'b1);
    fill_ramp();
    do_window("ramp", 16'd32640, 24'd5559680, 12'd2, 1'b1);

    // stall in VALID while the handler keeps offering a new window
    fill_const(8'h43);
    do_window("stall", 16'd17152, 24'd1149184, 12'd3, 1'b0);
    fill_const(8'h01);
    window_ready = 1'b1;
    stable_bad = 0;
    for (int n = 0; n < 50; n++) begin
      tick();
      if (ack !== 1'b0 || result_valid !== 1'b1 || win_sum !== 16'd17152 ||
          win_sos !== 24'd1149184 || window_index !== 12'd3)
        stable_bad++;
    end
    chk("stall_stable", 32'(stable_bad), 32'd0);
    result_ready = 1'b1;
    tick();
    chk("same_edge_valid", 32'(result_valid), 32'd0);
    chk("same_edge_no_ack", 32'(ack), 32'd0);
    result_ready = 1'b0;
    tick();
    chk("next_edge_ack", 32'(ack), 32'd1);
    window_ready = 1'b0;
    repeat (16) tick();
    chk("after_stall_valid", 32'(result_valid), 32'd1);
    chk("after_stall_sum", 32'(win_sum), 32'd256);
    chk("after_stall_sos", 32'(win_sos), 32'd256);
    chk("after_stall_idx", 32'(window_index), 32'd4);
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;

    // reset in the middle of accumulation
    fill_ramp();
    wait_ack("mid_rst");
    repeat (7) tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ack", 32'(ack), 32'd0);
    chk("mid_rst_valid", 32'(result_valid), 32'd0);
    chk("mid_rst_sum", 32'(win_sum), 32'd0);
    chk("mid_rst_sos", 32'(win_sos), 32'd0);
    chk("mid_rst_idx", 32'(window_index), 32'd0);
    #3;
    rst_n = 1'b1;
    do_window("post_rst", 16'd32640, 24'd5559680, 12'd0, 1'b1);

    // back-to-back windows through the index wrap
    #2;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    fill_const(8'h43);
    window_ready = 1'b1;
    result_ready = 1'b1;
    bulk_bad = 0;
    bulk_seen = 0;
    idx_4095 = 12'd0;
    idx_4096 = 12'd1;
    for (int w = 0; w < 4097; w++) begin
      got = 1'b0;
      for (int n = 0; n < 40 && !got; n++) begin
        tick();
        if (result_valid === 1'b1) begin
          got = 1'b1;
          bulk_seen++;
          if (window_index !== 12'(w) || win_sum !== 16'd17152) bulk_bad++;
          if (w == 4095) idx_4095 = window_index;
          if (w == 4096) idx_4096 = window_index;
        end
      end
      if (!got) break;
    end
    window_ready = 1'b0;
    result_ready = 1'b0;
    chk("bulk_seen", 32'(bulk_seen), 32'd4097);
    chk("bulk_bad", 32'(bulk_bad), 32'd0);
    chk("bulk_idx_4095", 32'(idx_4095), 32'd4095);
    chk("bulk_idx_wrap", 32'(idx_4096), 32'd0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
